// File: rtl/alu_responder_if.sv
// rtl/alu_responder_if.sv - request/response bundle between an ALU requester and the alu_responder
interface alu_responder_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_f;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_zero;
  logic             rsp_of;
  logic             rsp_illegal;

  modport master (
    output req_valid, req_f, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_zero, rsp_of, rsp_illegal
  );

  modport slave (
    input  req_valid, req_f, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_zero, rsp_of, rsp_illegal
  );
endinterface

// File: rtl/alu_responder.sv
// rtl/alu_responder.sv - two-stage handshaked ALU responder; ALU_RESPONDER_STATS_EN adds handshake counters
module alu_responder #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_responder_if.slave bus
`ifdef ALU_RESPONDER_STATS_EN
  ,
  output logic [31:0]   stat_ops,
  output logic [31:0]   stat_of
`endif
);

  typedef enum logic [2:0] {
    FN_AND  = 3'b000,
    FN_OR   = 3'b001,
    FN_ADD  = 3'b010,
    FN_ILL  = 3'b011,
    FN_ANDN = 3'b100,
    FN_ORN  = 3'b101,
    FN_SUB  = 3'b110,
    FN_SLT  = 3'b111
  } alu_fn_e;

  logic             s1_valid;
  alu_fn_e          s1_f;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic             s2_zero;
  logic             s2_of;
  logic             s2_illegal;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic             consume;

  logic [WIDTH-1:0] c_y;
  logic             c_of;
  logic             c_illegal;
  logic [WIDTH-1:0] c_sum;
  logic [WIDTH-1:0] c_diff;
  logic             c_lt;

  assign s2_free = !s2_valid || bus.rsp_ready;
  assign s1_adv  = s1_valid && s2_free;
  assign consume = s2_valid && bus.rsp_ready;

  // Gating with reset keeps the unit closed while reset is held, yet opens it
  // in the very first cycle after release.
  assign bus.req_ready = reset && (!s1_valid || s2_free);
  assign accept        = bus.req_valid && bus.req_ready;

  assign c_sum  = s1_a + s1_b;
  assign c_diff = s1_a - s1_b;
  assign c_lt   = $signed(s1_a) < $signed(s1_b);

  always_comb begin
    c_y       = '0;
    c_of      = 1'b0;
    c_illegal = 1'b0;
    case (s1_f)
      FN_AND:  c_y = s1_a & s1_b;
      FN_OR:   c_y = s1_a | s1_b;
      FN_ADD: begin
        c_y  = c_sum;
        c_of = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (c_sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      FN_ILL:  c_illegal = 1'b1;
      FN_ANDN: c_y = s1_a & ~s1_b;
      FN_ORN:  c_y = s1_a | ~s1_b;
      FN_SUB: begin
        c_y  = c_diff;
        c_of = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (c_diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      FN_SLT:  c_y = {{(WIDTH-1){1'b0}}, c_lt};
      default: c_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Payload is captured only on accept so a stalled stage 1 keeps its operands.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_f <= alu_fn_e'(bus.req_f);
      s1_a <= bus.req_a;
      s1_b <= bus.req_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid   <= 1'b0;
      s2_y       <= '0;
      s2_zero    <= 1'b0;
      s2_of      <= 1'b0;
      s2_illegal <= 1'b0;
    end else if (s1_adv) begin
      s2_valid   <= 1'b1;
      s2_y       <= c_y;
      s2_zero    <= (c_y == '0);
      s2_of      <= c_of;
      s2_illegal <= c_illegal;
    end else if (consume) begin
      s2_valid   <= 1'b0;
    end
  end

  assign bus.rsp_valid   = s2_valid;
  assign bus.rsp_y       = s2_y;
  assign bus.rsp_zero    = s2_zero;
  assign bus.rsp_of      = s2_of;
  assign bus.rsp_illegal = s2_illegal;

`ifdef ALU_RESPONDER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_ops <= '0;
      stat_of  <= '0;
    end else if (consume) begin
      stat_ops <= stat_ops + 32'd1;
      if (s2_of) begin
        stat_of <= stat_of + 32'd1;
      end
    end
  end
`endif

endmodule
